// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: next-PC selection, single-outstanding imem handshake,
// one-entry decode buffer and squash of responses made stale by a redirect.
module fetch_ctrl #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic [31:0] i_pc,
   output logic [31:0] o_next_pc,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   output logic        o_fault
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StFault} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_squash;
   logic        w_squash_nxt;
   logic        r_fault_pend;
   logic        w_fault_pend_nxt;
   logic [31:0] r_req_addr;
   logic        r_inst_valid;
   logic [31:0] r_inst;
   logic [31:0] r_inst_pc;
   logic        r_fault;

   logic w_free;
   logic w_misalign;
   logic w_req;
   logic w_gnt;
   logic w_rsp;
   logic w_capture;

   assign w_free     = !r_inst_valid || !i_stall;
   assign w_misalign = (i_redirect_pc[1:0] != 2'b00);
   assign w_req      = (r_state == StReq) && w_free;
   assign w_gnt      = w_req && i_imem_gnt;
   assign w_rsp      = (r_state == StWait) && i_imem_rvalid;
   // A response coinciding with a redirect belongs to the wrong path.
   assign w_capture  = w_rsp && !r_squash && !i_redirect;

   always_comb begin
      w_state_nxt      = r_state;
      w_squash_nxt     = r_squash;
      w_fault_pend_nxt = r_fault_pend;
      unique case (r_state)
         StIdle:  w_state_nxt = StReq;
         StReq:   if (w_gnt) w_state_nxt = StWait;
         StWait: begin
            if (w_rsp) begin
               w_squash_nxt     = 1'b0;
               w_fault_pend_nxt = 1'b0;
               w_state_nxt      = r_fault_pend ? StFault : StReq;
            end
         end
         StFault: w_state_nxt = StFault;
         default: w_state_nxt = StIdle;
      endcase

      if (i_redirect) begin
         if (r_state == StFault) begin
            if (!w_misalign) w_state_nxt = StReq;
         end else begin
            // Any request still in flight after this cycle must be drained and dropped.
            w_squash_nxt     = ((r_state == StWait) && !i_imem_rvalid) || w_gnt;
            w_fault_pend_nxt = w_squash_nxt && w_misalign;
            if (w_squash_nxt)    w_state_nxt = StWait;
            else if (w_misalign) w_state_nxt = StFault;
            else                 w_state_nxt = StReq;
         end
      end
   end

   always_comb begin
      o_next_pc = i_pc;
      if (i_rst)           o_next_pc = RESET_ADDR;
      else if (i_redirect) o_next_pc = i_redirect_pc;
      else if (w_gnt)      o_next_pc = i_pc + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_squash     <= 1'b0;
         r_fault_pend <= 1'b0;
         r_req_addr   <= 32'h0000_0000;
         r_inst_valid <= 1'b0;
         r_inst       <= 32'h0000_0013;
         r_inst_pc    <= 32'h0000_0000;
         r_fault      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_squash     <= w_squash_nxt;
         r_fault_pend <= w_fault_pend_nxt;
         r_fault      <= i_redirect && w_misalign;
         if (w_gnt) r_req_addr <= i_pc;
         if (i_redirect && (r_state != StFault)) begin
            r_inst_valid <= 1'b0;
         end else if (w_capture) begin
            r_inst_valid <= 1'b1;
            r_inst       <= i_imem_rdata;
            r_inst_pc    <= r_req_addr;
         end else if (r_inst_valid && !i_stall) begin
            r_inst_valid <= 1'b0;
         end
      end
   end

   assign o_imem_req   = w_req;
   assign o_imem_addr  = i_pc;
   assign o_inst_valid = r_inst_valid;
   assign o_inst       = r_inst;
   assign o_inst_pc    = r_inst_pc;
   assign o_fault      = r_fault;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: cycle table for the basic fetch/stall flow, then
// hand sequences for squash, misaligned-redirect fault, reset-in-WAIT and PC wrap.
module tb_fetch_ctrl;

   logic        clk;
   logic        i_rst;
   logic [31:0] r_pc;
   logic [31:0] w_next_pc;
   logic        i_stall;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        w_req;
   logic [31:0] w_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        w_inst_valid;
   logic [31:0] w_inst;
   logic [31:0] w_inst_pc;
   logic        w_fault;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_ctrl #(.RESET_ADDR(32'h0000_0000)) dut (
      .clk           (clk),
      .i_rst         (i_rst),
      .i_pc          (r_pc),
      .o_next_pc     (w_next_pc),
      .i_stall       (i_stall),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_imem_req    (w_req),
      .o_imem_addr   (w_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .o_inst_valid  (w_inst_valid),
      .o_inst        (w_inst),
      .o_inst_pc     (w_inst_pc),
      .o_fault       (w_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the pc register.
   always_ff @(posedge clk) r_pc <= w_next_pc;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] addr;
      logic [31:0] npc;
      logic        vld;
      logic [31:0] inst;
      logic [31:0] ipc;
      logic        flt;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs mid-cycle and let combinational outputs settle.
   task automatic cyc(input logic rst, input logic stall, input logic redir,
                      input logic [31:0] rpc, input logic gnt, input logic rvalid,
                      input logic [31:0] rdata);
      @(negedge clk);
      i_rst         = rst;
      i_stall       = stall;
      i_redirect    = redir;
      i_redirect_pc = rpc;
      i_imem_gnt    = gnt;
      i_imem_rvalid = rvalid;
      i_imem_rdata  = rdata;
      #2;
   endtask

   initial begin
      vecs[0]  = '{1, 0, 0, 0, 32'h0,         0, 32'h00, 32'h00, 0, 32'h13,        32'h0, 0};
      vecs[1]  = '{0, 0, 1, 0, 32'h0,         0, 32'h00, 32'h00, 0, 32'h13,        32'h0, 0};
      vecs[2]  = '{0, 0, 1, 0, 32'h0,         1, 32'h00, 32'h04, 0, 32'h13,        32'h0, 0};
      vecs[3]  = '{0, 0, 1, 1, 32'hA000_0000, 0, 32'h04, 32'h04, 0, 32'h13,        32'h0, 0};
      vecs[4]  = '{0, 0, 1, 0, 32'h0,         1, 32'h04, 32'h08, 1, 32'hA000_0000, 32'h0, 0};
      vecs[5]  = '{0, 0, 1, 1, 32'hA000_0004, 0, 32'h08, 32'h08, 0, 32'hA000_0000, 32'h0, 0};
      vecs[6]  = '{0, 0, 1, 0, 32'h0,         1, 32'h08, 32'h0C, 1, 32'hA000_0004, 32'h4, 0};
      vecs[7]  = '{0, 0, 1, 1, 32'hA000_0008, 0, 32'h0C, 32'h0C, 0, 32'hA000_0004, 32'h4, 0};
      for (int i = 8; i <= 12; i++)
         vecs[i] = '{0, 1, 1, 0, 32'h0,       0, 32'h0C, 32'h0C, 1, 32'hA000_0008, 32'h8, 0};
      vecs[13] = '{0, 0, 1, 0, 32'h0,         1, 32'h0C, 32'h10, 1, 32'hA000_0008, 32'h8, 0};
      vecs[14] = '{0, 0, 1, 1, 32'hA000_000C, 0, 32'h10, 32'h10, 0, 32'hA000_0008, 32'h8, 0};
      vecs[15] = '{0, 0, 0, 0, 32'h0,         1, 32'h10, 32'h10, 1, 32'hA000_000C, 32'hC, 0};
      vecs[16] = '{0, 0, 1, 0, 32'h0,         1, 32'h10, 32'h14, 0, 32'hA000_000C, 32'hC, 0};

      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 17; i++) begin
         cyc(vecs[i].rst, vecs[i].stall, 1'b0, 32'h0, vecs[i].gnt, vecs[i].rvalid,
             vecs[i].rdata);
         chk($sformatf("v%0d.req", i),   {31'b0, w_req},        {31'b0, vecs[i].req});
         chk($sformatf("v%0d.addr", i),  w_addr,                vecs[i].addr);
         chk($sformatf("v%0d.npc", i),   w_next_pc,             vecs[i].npc);
         chk($sformatf("v%0d.vld", i),   {31'b0, w_inst_valid}, {31'b0, vecs[i].vld});
         chk($sformatf("v%0d.inst", i),  w_inst,                vecs[i].inst);
         chk($sformatf("v%0d.ipc", i),   w_inst_pc,             vecs[i].ipc);
         chk($sformatf("v%0d.fault", i), {31'b0, w_fault},      {31'b0, vecs[i].flt});
      end

      // Redirect during WAIT: the late response is dropped, fetch resumes at the target.
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("sq.req0", {31'b0, w_req}, 32'd1);
      cyc(0, 0, 1, 32'h100, 0, 0, 0);
      chk("sq.npc_redir", w_next_pc, 32'h100);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("sq.drain_req", {31'b0, w_req}, 32'd0);
      chk("sq.drain_vld", {31'b0, w_inst_valid}, 32'd0);
      cyc(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
      chk("sq.stale_req", {31'b0, w_req}, 32'd0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("sq.req1", {31'b0, w_req}, 32'd1);
      chk("sq.addr1", w_addr, 32'h100);
      chk("sq.vld_dropped", {31'b0, w_inst_valid}, 32'd0);
      cyc(0, 0, 0, 0, 0, 1, 32'hA000_0100);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("sq.vld", {31'b0, w_inst_valid}, 32'd1);
      chk("sq.inst", w_inst, 32'hA000_0100);
      chk("sq.ipc", w_inst_pc, 32'h100);

      // Misaligned redirect: one-cycle fault, halt, then an aligned redirect resumes.
      cyc(0, 0, 1, 32'h102, 0, 0, 0);
      chk("flt.npc", w_next_pc, 32'h102);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("flt.pulse", {31'b0, w_fault}, 32'd1);
      chk("flt.req_a", {31'b0, w_req}, 32'd0);
      chk("flt.vld", {31'b0, w_inst_valid}, 32'd0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("flt.pulse_end", {31'b0, w_fault}, 32'd0);
      chk("flt.req_b", {31'b0, w_req}, 32'd0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("flt.req_c", {31'b0, w_req}, 32'd0);
      chk("flt.pc_hold", w_next_pc, 32'h102);
      cyc(0, 0, 1, 32'h200, 0, 0, 0);
      chk("flt.npc_exit", w_next_pc, 32'h200);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("flt.req_resume", {31'b0, w_req}, 32'd1);
      chk("flt.addr_resume", w_addr, 32'h200);
      chk("flt.npc_resume", w_next_pc, 32'h204);
      chk("flt.no_pulse", {31'b0, w_fault}, 32'd0);

      // Reset while in WAIT, late rvalid afterwards is ignored.
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("rst.npc", w_next_pc, 32'h0);
      cyc(0, 0, 0, 0, 0, 1, 32'h0000_0BAD);
      chk("rst.idle_req", {31'b0, w_req}, 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("rst.req", {31'b0, w_req}, 32'd1);
      chk("rst.addr", w_addr, 32'h0);
      chk("rst.vld", {31'b0, w_inst_valid}, 32'd0);
      chk("rst.inst", w_inst, 32'h13);

      // PC wrap on a grant at the top of the address space.
      cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
      chk("wrap.npc_redir", w_next_pc, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("wrap.addr", w_addr, 32'hFFFF_FFFC);
      chk("wrap.npc", w_next_pc, 32'h0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("wrap.pc", w_addr, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
